// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Constants shared between the phase sequencer, its decoder
//                interface and the button conditioning logic: state
//                encodings, phase numbers and flag bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Sequencer states (2-bit encoding)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // Phase numbers; PH_DECODE is the only phase where halt_req is honoured
  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_FETCH  = 3'd1;
  localparam logic [2:0] PH_DECODE = 3'd2;

  // Flag vector layout {S,Z,C,V}
  localparam int FLAG_W = 4;
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [2:0] phase_inc(input logic [2:0] p);
    return p + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer_if
//  Description : Bundle between the phase sequencer and the control decoder /
//                ALU. master = sequencer, slave = decoder side.
//                  halt_req   decoder -> seq  HLT decoded (valid phase>=2)
//                  flags_in   ALU     -> seq  {S,Z,C,V}
//                  flags_we   decoder -> seq  flag register write enable
//                  phase      seq -> decoder  current phase, 0 = idle
//                  phase_last seq -> decoder  last phase (PC update strobe)
//                  flags_out  seq -> decoder  registered {S,Z,C,V}
//  Revision    : 1.0 - initial release
// ============================================================================
interface phase_sequencer_if;
  import cpu_pkg::*;

  logic              halt_req;
  logic [FLAG_W-1:0] flags_in;
  logic              flags_we;
  logic [2:0]        phase;
  logic              phase_last;
  logic [FLAG_W-1:0] flags_out;

  modport master (
    input  halt_req, flags_in, flags_we,
    output phase, phase_last, flags_out
  );

  modport slave (
    output halt_req, flags_in, flags_we,
    input  phase, phase_last, flags_out
  );

endinterface
`default_nettype wire

// File: rtl/button_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : button_sync_edge
//  Description : Synchronises a raw push-button level into the clk domain
//                and emits a one-cycle pulse on each rising level. The pulse
//                is combinational from the last sync flop and its delayed
//                copy, so it is seen SYNC_STAGES cycles after the raw rise
//                and acted on at the following edge.
//  Ports       : clk        system clock
//                rst        asynchronous active-low reset
//                din        raw level, asynchronous to clk
//                edge_pulse one-cycle rising-edge pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module button_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Instruction phase generator for the control decoder. Turns
//                the exec/step buttons into run/stop/single-step control at
//                instruction boundaries, stops on HLT, owns the S/Z/C/V flag
//                register and counts retired instructions.
//  Ports       : clk          system clock
//                rst          asynchronous active-low reset
//                exec, step   raw button levels (asynchronous)
//                bus          decoder bundle (master side)
//                running      state is RUN or STEP
//                halted       state is HALT
//                instr_count  retired-instruction count (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_PHASES  = 5,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exec,
  input  logic                 step,
  phase_sequencer_if.master    bus,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [2:0]       C_LAST = 3'(NUM_PHASES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic exec_edge;
  logic step_edge;

  logic [1:0]        state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic              stop_q,  stop_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [FLAG_W-1:0] flags_q;

  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_exec_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (exec),
    .edge_pulse (exec_edge)
  );

  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (step),
    .edge_pulse (step_edge)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_IDLE;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    stop_d  = stop_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        // exec takes precedence over a simultaneous step edge
        if (exec_edge) begin
          state_d = ST_RUN;
          phase_d = PH_FETCH;
        end else if (step_edge) begin
          state_d = ST_STEP;
          phase_d = PH_FETCH;
        end
      end

      ST_RUN: begin
        // Each exec edge toggles the pending stop so a second press cancels it
        if (exec_edge) stop_d = ~stop_q;

        // HLT outranks both the pending stop and the boundary (NUM_PHASES==2)
        if (phase_q == PH_DECODE && bus.halt_req) begin
          state_d = ST_HALT;
          phase_d = PH_IDLE;
          stop_d  = 1'b0;
          cnt_d   = cnt_q + C_ONE;
        end else if (phase_q == C_LAST) begin
          cnt_d = cnt_q + C_ONE;
          if (stop_q) begin
            state_d = ST_IDLE;
            phase_d = PH_IDLE;
            stop_d  = 1'b0;
          end else begin
            phase_d = PH_FETCH;
          end
        end else begin
          phase_d = phase_inc(phase_q);
        end
      end

      ST_STEP: begin
        if (phase_q == PH_DECODE && bus.halt_req) begin
          state_d = ST_HALT;
          phase_d = PH_IDLE;
          cnt_d   = cnt_q + C_ONE;
        end else if (phase_q == C_LAST) begin
          state_d = ST_IDLE;
          phase_d = PH_IDLE;
          cnt_d   = cnt_q + C_ONE;
        end else begin
          phase_d = phase_inc(phase_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
        stop_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (straight from registered state, no added latency)
  // --------------------------------------------------------------------------
  always_comb begin
    running        = (state_q == ST_RUN) || (state_q == ST_STEP);
    halted         = (state_q == ST_HALT);
    bus.phase_last = (phase_q == C_LAST);
  end

  // Flag register: writes outside an instruction are discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
    end else if (bus.flags_we && phase_q != PH_IDLE) begin
      flags_q <= bus.flags_in;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.flags_out = flags_q;
  assign instr_count   = cnt_q;

endmodule
`default_nettype wire
